// File: rtl/sram_like_arbiter.sv
// Two-master (instruction/data) to one-slave arbiter for sram-like bus transactions.
// Data wins by default; a starvation counter forces an instruction grant after STARVE_MAX data wins.
module sram_like_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              inst_req,
    input  logic              inst_wr,
    input  logic [1:0]        inst_size,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic [DATA_W-1:0] inst_wdata,
    output logic [DATA_W-1:0] inst_rdata,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,

    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic [DATA_W-1:0] data_rdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,

    output logic              bus_req,
    output logic              bus_wr,
    output logic [1:0]        bus_size,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_addr_ok,
    input  logic              bus_data_ok
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t     state_q, state_d;
    logic       owner_q, owner_d;   // 0 = inst, 1 = data
    logic [3:0] starve_q, starve_d;

    logic grant_inst, grant_data, granted, sel, cur;
    logic active, accept, done;

    // Arbitration is only consulted in IDLE; afterwards the latched owner steers the bus.
    always_comb begin
        grant_inst = inst_req && (!data_req || starve_q == STARVE_LIM);
        grant_data = data_req && !grant_inst;
        granted    = grant_inst || grant_data;
        sel        = grant_data;
        cur        = (state_q == IDLE) ? sel : owner_q;
        active     = ((state_q == IDLE) && granted) || (state_q == ADDR);
        accept     = active && bus_addr_ok;
        // A data_ok outside DATA or an accept cycle belongs to an abandoned transaction.
        done       = bus_data_ok && ((state_q == DATA) || accept);
    end

    always_comb begin
        bus_req      = !rst && active;
        bus_wr       = cur ? data_wr    : inst_wr;
        bus_size     = cur ? data_size  : inst_size;
        bus_addr     = cur ? data_addr  : inst_addr;
        bus_wdata    = cur ? data_wdata : inst_wdata;
        inst_rdata   = bus_rdata;
        data_rdata   = bus_rdata;
        inst_addr_ok = !rst && accept && !cur;
        data_addr_ok = !rst && accept &&  cur;
        inst_data_ok = !rst && done   && !cur;
        data_data_ok = !rst && done   &&  cur;
    end

    // NOTE: every variable gets a default before the case so no path infers a latch.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        starve_d = starve_q;
        unique case (state_q)
            IDLE: begin
                if (granted) begin
                    owner_d = sel;
                    if (!bus_addr_ok)      state_d = ADDR;
                    else if (!bus_data_ok) state_d = DATA;
                end
            end
            ADDR: begin
                if (bus_addr_ok) state_d = bus_data_ok ? IDLE : DATA;
            end
            DATA: begin
                if (bus_data_ok) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            if (cur && inst_req)
                starve_d = (starve_q >= STARVE_LIM) ? STARVE_LIM : starve_q + 4'd1;
            else
                starve_d = 4'd0;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            starve_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            starve_q <= starve_d;
        end
    end

endmodule
